write_ptr_ctrl: RTL and testbench
=================================

// Module: write_ptr_ctrl
// PURPOSE
//   Write-side pointer/flag controller of the async FIFO; the counterpart of the read-side pointer logic.
//   Lives entirely in the write clock domain.
//   Brings the read-domain gray pointer in through a 2-flop synchronizer.
//   Maintains binary/gray write pointers, drives the memory write enable and address,
//   and generates registered full, almost_full, fill level and a sticky overflow flag.
// PARAMETERS
//   PTR_WIDTH  4   address bits; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits
//   AF_THRESH  12  almost_full asserts when the registered level >= AF_THRESH (1..2**PTR_WIDTH)
// PORTS
//   w_clk        in   1            write-domain clock (sole clock)
//   w_rst        in   1            asynchronous, active-high reset
//   w_en         in   1            write request
//   g_read_ptr   in   PTR_WIDTH+1  gray read pointer from read domain (asynchronous to w_clk)
//   ovf_clr      in   1            clears sticky overflow
//   b_write_ptr  out  PTR_WIDTH+1  binary write pointer (registered)
//   g_write_ptr  out  PTR_WIDTH+1  gray write pointer (registered), sent to read-domain synchronizer
//   w_addr       out  PTR_WIDTH    memory write address = b_write_ptr[PTR_WIDTH-1:0]
//   w_mem_en     out  1            memory write strobe = w_en & ~full (combinational)
//   full         out  1            FIFO full (registered)
//   almost_full  out  1            level >= AF_THRESH (registered)
//   w_level      out  PTR_WIDTH+1  write-side fill level, 0..2**PTR_WIDTH (registered, pessimistic)
//   overflow     out  1            sticky: a write was attempted while full
// BEHAVIOUR
//   - Reset (w_rst=1, async): sync stages, b/g_write_ptr, w_level = 0; full, almost_full, overflow = 0.
//     Applies mid-operation without waiting for w_clk. Deassertion is taken at the next w_clk edge.
//   - Synchronizer: rq1 <= g_read_ptr; rq2 <= rq1; only rq2 is used downstream.
//   - rb = gray-to-binary(rq2): rb[MSB] = rq2[MSB]; rb[i] = rb[i+1] ^ rq2[i].
//   - wb_next = b_write_ptr + (w_en & ~full), modulo 2**(PTR_WIDTH+1) (natural wrap).
//     wg_next = (wb_next >> 1) ^ wb_next. Both registered each w_clk.
//   - full_next = (wg_next == {~rq2[PTR_WIDTH:PTR_WIDTH-1], rq2[PTR_WIDTH-2:0]}); full <= full_next.
//     full asserts on the same edge that registers the write filling the last slot.
//   - level_next = wb_next - rb (PTR_WIDTH+1 bits, modulo); w_level <= level_next;
//     almost_full <= (level_next >= AF_THRESH).
//   - The write path never holds state other than the pointers: a write accepted at edge k uses
//     w_addr = b_write_ptr before edge k.
//   - Write while full: w_mem_en = 0; pointers unchanged; overflow <= 1 at that edge.
//   - overflow priority: set (w_en & full) beats ovf_clr on the same edge; otherwise ovf_clr clears it.
//   - Read-side release latency: a change on g_read_ptr is visible in full/level/almost_full
//     3 w_clk edges later (2 sync + 1 flag register). Flags are conservative: may be stale high, never stale low.
//   - PTR_WIDTH >= 2 is required; AF_THRESH = 2**PTR_WIDTH makes almost_full track full.
// TESTING
//   1 Reset mid-stream: after 5 writes, pulse w_rst -> all outputs 0 immediately, before any w_clk edge.
//   2 Fill: g_read_ptr=0, w_en=1 for 16 cycles -> after the 16th edge b_write_ptr=5'b10000,
//     g_write_ptr=5'b11000, full=1, w_level=16; almost_full=1 from the 12th edge.
//   3 Overflow: full=1, w_en=1 for 1 cycle -> w_mem_en=0, pointers hold, overflow=1;
//     ovf_clr=1 with w_en=0 -> overflow=0; ovf_clr=1 with w_en=1 while full -> overflow stays 1.
//   4 Release: full, then drive g_read_ptr=5'b00001 at edge k -> full=0 and w_level=15 after edge k+3.
//   5 Wrap: stream 40 writes with g_read_ptr tracking 2 entries behind -> b_write_ptr wraps 31->0,
//     full never asserts, w_addr sequence is continuous mod 16.
//   6 Simultaneous: w_en=1 on the cycle the level drops from 16 to 15 at rq2 -> write accepted that
//     cycle, full re-asserts on the next edge.

Source files
------------

// File: rtl/write_ptr_ctrl_if.sv
// ----------------------------------------------------------------------------
// write_ptr_ctrl_if
//   Bundles the write-side request/flag signals of the async FIFO write
//   controller. The master is the write-side client, which drives the write
//   request and the overflow clear. In the bench, the master also supplies the
//   read-domain gray pointer. The slave is write_ptr_ctrl.
//   Signals:
//     w_en        write request
//     g_read_ptr  gray read pointer from the read domain (async to w_clk)
//     ovf_clr     clears the sticky overflow flag
//     b_write_ptr binary write pointer
//     g_write_ptr gray write pointer toward the read-domain synchronizer
//     w_addr      memory write address
//     w_mem_en    memory write strobe
//     full        FIFO full
//     almost_full level >= AF_THRESH
//     w_level     pessimistic write-side fill level
//     overflow    sticky write-while-full flag
// ----------------------------------------------------------------------------
interface write_ptr_ctrl_if #(
    parameter int unsigned PTR_WIDTH = 4
);
    logic                 w_en;
    logic [PTR_WIDTH:0]   g_read_ptr;
    logic                 ovf_clr;
    logic [PTR_WIDTH:0]   b_write_ptr;
    logic [PTR_WIDTH:0]   g_write_ptr;
    logic [PTR_WIDTH-1:0] w_addr;
    logic                 w_mem_en;
    logic                 full;
    logic                 almost_full;
    logic [PTR_WIDTH:0]   w_level;
    logic                 overflow;

    modport master (
        output w_en, g_read_ptr, ovf_clr,
        input  b_write_ptr, g_write_ptr, w_addr, w_mem_en,
               full, almost_full, w_level, overflow
    );

    modport slave (
        input  w_en, g_read_ptr, ovf_clr,
        output b_write_ptr, g_write_ptr, w_addr, w_mem_en,
               full, almost_full, w_level, overflow
    );
endinterface

// File: rtl/write_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// write_ptr_ctrl
//   Write-side pointer and flag controller of the async FIFO. The whole module
//   runs in the w_clk domain.
//   The read-domain gray pointer is brought in through a 2-flop synchronizer.
//   The module keeps the binary and gray write pointers and drives the memory
//   write strobe and address. It also produces these registered outputs:
//   full, almost_full, the fill level and a sticky overflow flag.
//   Ports:
//     w_clk  write clock
//     w_rst  asynchronous active-high reset
//     bus    write_ptr_ctrl_if.slave (request inputs, pointer/flag outputs)
//   Flags are computed against the synchronized read pointer. They can
//   therefore stay high for a few cycles after a read, but they never
//   de-assert early.
// ----------------------------------------------------------------------------
module write_ptr_ctrl #(
    parameter int unsigned PTR_WIDTH = 4,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic              w_clk,
    input  logic              w_rst,
    write_ptr_ctrl_if.slave   bus
);
    localparam int unsigned PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AF_LVL = PW'(AF_THRESH);

    logic [PTR_WIDTH:0] rq1;
    logic [PTR_WIDTH:0] rq2;
    logic [PTR_WIDTH:0] rb;
    logic [PTR_WIDTH:0] b_ptr;
    logic [PTR_WIDTH:0] g_ptr;
    logic [PTR_WIDTH:0] wb_next;
    logic [PTR_WIDTH:0] wg_next;
    logic [PTR_WIDTH:0] full_cmp;
    logic [PTR_WIDTH:0] level_next;
    logic [PTR_WIDTH:0] level_q;
    logic               full_q;
    logic               af_q;
    logic               ovf_q;
    logic               mem_en;

    // The write is suppressed while full, so a write when full only sets overflow.
    assign mem_en = bus.w_en & ~full_q;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        rb            = '0;
        rb[PTR_WIDTH] = rq2[PTR_WIDTH];
        for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
            rb[PTR_WIDTH-1-i] = rb[PTR_WIDTH-i] ^ rq2[PTR_WIDTH-1-i];
        end
    end

    always_comb begin
        wb_next    = b_ptr + {{PTR_WIDTH{1'b0}}, mem_en};
        wg_next    = (wb_next >> 1) ^ wb_next;
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        // In gray code, that means the two MSBs are inverted and the rest match.
        full_cmp   = {~rq2[PTR_WIDTH:PTR_WIDTH-1], rq2[PTR_WIDTH-2:0]};
        level_next = wb_next - rb;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rq1     <= '0;
            rq2     <= '0;
            b_ptr   <= '0;
            g_ptr   <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rq1     <= bus.g_read_ptr;
            rq2     <= rq1;
            b_ptr   <= wb_next;
            g_ptr   <= wg_next;
            full_q  <= (wg_next == full_cmp);
            level_q <= level_next;
            af_q    <= (level_next >= AF_LVL);
            // A rejected write sets overflow and wins over a clear on the same edge.
            if (bus.w_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.b_write_ptr = b_ptr;
    assign bus.g_write_ptr = g_ptr;
    assign bus.w_addr      = b_ptr[PTR_WIDTH-1:0];
    assign bus.w_mem_en    = mem_en;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.w_level     = level_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_write_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_write_ptr_ctrl
//   Bench for write_ptr_ctrl (PTR_WIDTH=4, AF_THRESH=12).
//   The reference model tracks the total number of accepted writes as a plain
//   integer. The read count is recovered from the delayed gray read pointer.
//   The fill level, full and almost_full flags are then derived arithmetically
//   from those two counts.
// ----------------------------------------------------------------------------
module tb_write_ptr_ctrl;
    localparam int DEPTH = 16;
    localparam int MODV  = 32;

    logic w_clk;
    logic w_rst;

    write_ptr_ctrl_if #(.PTR_WIDTH(4)) wif ();

    write_ptr_ctrl #(.PTR_WIDTH(4), .AF_THRESH(12)) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (wif)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray2bin(input int g);
        int b;
        b = 0;
        for (int s = 0; s < 5; s++) b = b ^ (g >> s);
        return b & (MODV - 1);
    endfunction

    function automatic int bin2gray(input int b);
        return (b ^ (b >> 1)) & (MODV - 1);
    endfunction

    // ---------------- reference model ----------------
    int m_wr_total;
    int m_d1, m_d2;          // read pointer as seen 1 and 2 edges later
    int m_level;
    bit m_full, m_af, m_ovf;

    always @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            m_wr_total = 0;
            m_d1 = 0; m_d2 = 0;
            m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            int rd;
            if (wif.w_en && m_full) m_ovf = 1;
            else if (wif.ovf_clr)   m_ovf = 0;
            if (wif.w_en && !m_full) m_wr_total++;
            rd      = gray2bin(m_d2);
            m_level = (m_wr_total - rd) & (MODV - 1);
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= 12);
            m_d2    = m_d1;
            m_d1    = int'(wif.g_read_ptr);
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge w_clk) begin
        if (!w_rst) begin
            int wb;
            wb = m_wr_total & (MODV - 1);
            check("b_write_ptr", int'(wif.b_write_ptr), wb);
            check("g_write_ptr", int'(wif.g_write_ptr), bin2gray(wb));
            check("w_addr",      int'(wif.w_addr),      wb % DEPTH);
            check("w_mem_en",    int'(wif.w_mem_en),    int'(wif.w_en && !m_full));
            check("full",        int'(wif.full),        int'(m_full));
            check("almost_full", int'(wif.almost_full), int'(m_af));
            check("w_level",     int'(wif.w_level),     m_level);
            check("overflow",    int'(wif.overflow),    int'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    int rd_total;

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        step();
        step();
        w_rst = 1'b0;
        rd_total = 0;
    endtask

    initial begin
        w_rst          = 1'b1;
        wif.w_en       = 1'b0;
        wif.ovf_clr    = 1'b0;
        wif.g_read_ptr = '0;
        rd_total       = 0;
        do_reset();
        check("rst_b_ptr", int'(wif.b_write_ptr), 0);
        check("rst_full",  int'(wif.full), 0);
        check("rst_ovf",   int'(wif.overflow), 0);

        // 1: async reset mid-stream after 5 writes
        wif.w_en = 1'b1;
        repeat (5) step();
        check("pre_rst_b_ptr", int'(wif.b_write_ptr), 5);
        wif.w_en = 1'b0;
        #2 w_rst = 1'b1;
        #1;
        check("async_rst_b_ptr", int'(wif.b_write_ptr), 0);
        check("async_rst_g_ptr", int'(wif.g_write_ptr), 0);
        check("async_rst_level", int'(wif.w_level), 0);
        check("async_rst_addr",  int'(wif.w_addr), 0);
        w_rst = 1'b0;
        step();

        // 2: fill with read pointer held at 0
        wif.g_read_ptr = '0;
        wif.w_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 11) check("af_at_11", int'(wif.almost_full), 0);
            if (i == 12) check("af_at_12", int'(wif.almost_full), 1);
            if (i == 15) check("full_at_15", int'(wif.full), 0);
        end
        check("fill_b_ptr", int'(wif.b_write_ptr), 16);
        check("fill_g_ptr", int'(wif.g_write_ptr), 24);
        check("fill_full",  int'(wif.full), 1);
        check("fill_level", int'(wif.w_level), 16);
        check("model_full", int'(m_full), 1);

        // 3: overflow behaviour
        check("ovf_mem_en", int'(wif.w_mem_en), 0);
        step();
        check("ovf_b_ptr_hold", int'(wif.b_write_ptr), 16);
        check("ovf_set", int'(wif.overflow), 1);
        wif.w_en = 1'b0;
        wif.ovf_clr = 1'b1;
        step();
        check("ovf_cleared", int'(wif.overflow), 0);
        wif.w_en = 1'b1;
        step();
        check("ovf_set_beats_clr", int'(wif.overflow), 1);
        wif.w_en = 1'b0;
        wif.ovf_clr = 1'b0;

        // 4: release one entry; visible three edges later
        wif.g_read_ptr = 5'b00001;
        step();
        step();
        check("release_k2_full", int'(wif.full), 1);
        step();
        check("release_k3_full",  int'(wif.full), 0);
        check("release_k3_level", int'(wif.w_level), 15);

        // 6: write on the cycle the level has dropped to 15
        wif.w_en = 1'b1;
        #1;
        check("simul_mem_en", int'(wif.w_mem_en), 1);
        step();
        check("simul_full",  int'(wif.full), 1);
        check("simul_b_ptr", int'(wif.b_write_ptr), 17);
        check("simul_level", int'(wif.w_level), 16);
        wif.w_en = 1'b0;

        // 5: wrap with the reader trailing two entries behind
        wif.g_read_ptr = '0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wif.w_en = 1'b1;
            wif.g_read_ptr = 5'(bin2gray(((i >= 2) ? i - 2 : 0) % MODV));
            #1;
            check("wrap_addr", int'(wif.w_addr), i % DEPTH);
            check("wrap_not_full", int'(wif.full), 0);
            step();
        end
        check("wrap_b_ptr", int'(wif.b_write_ptr), 8);
        wif.w_en = 1'b0;

        // random phases: alternate write-heavy and read-heavy bias
        wif.g_read_ptr = '0;
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int wp, rp;
            wp = (seg % 2 == 0) ? 85 : 30;
            rp = (seg % 2 == 0) ? 20 : 80;
            for (int c = 0; c < 300; c++) begin
                if (seg == 4 && c == 150) begin
                    #2 w_rst = 1'b1;
                    #1 w_rst = 1'b0;
                    rd_total = 0;
                    wif.g_read_ptr = '0;
                end
                wif.w_en    = ($urandom_range(0, 99) < wp);
                wif.ovf_clr = ($urandom_range(0, 99) < 10);
                if (rd_total < m_wr_total && $urandom_range(0, 99) < rp) rd_total++;
                wif.g_read_ptr = 5'(bin2gray(rd_total % MODV));
                step();
            end
        end
        wif.w_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
